id_stage_pipe: RTL

Registered, handshaked successor to the combinational decode stage. It decodes one RV32I instruction per cycle, reads the register file combinationally and latches operands into an output pipeline register with valid/ready flow control. It adds a load-use scoreboard, a pipeline flush, RV32E support and illegal-instruction flagging. It sits between if_id and id_ex.

---
 rtl/id_stage_pipe.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// Registered RV32I/RV32E decode stage: decodes, reads operands, and holds them in a
// valid/ready output register with a load-use scoreboard, flush and illegal-instruction flag.
module id_stage_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              flush_i,
    input  logic              wb_clr_valid_i,
    input  logic [REG_AW-1:0] wb_clr_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [XLEN-1:0]   aux_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_wen_o,
    output logic              is_load_o,
    output logic              illegal_o,
    output logic              stall_o
);

    localparam int unsigned NumRegs = 1 << REG_AW;

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1_f, rs2_f, rd_f;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rs1_f  = inst_i[19:15];
    assign rs2_f  = inst_i[24:20];
    assign rd_f   = inst_i[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign imm_i = XLEN'($signed(inst_i[31:20]));
    assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));

    logic            legal, use_rs1, use_rs2, use_rd, load_raw;
    logic [XLEN-1:0] op1_raw, op2_raw, aux_raw;

    always_comb begin
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        load_raw = 1'b0;
        op1_raw  = '0;
        op2_raw  = '0;
        aux_raw  = '0;
        case (opcode)
            OpcOpImm: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                op1_raw = rs1_data_i;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    op2_raw = XLEN'(rs2_f);
                    legal   = (funct7 == 7'h00) || (funct3 == 3'b101 && funct7 == 7'h20);
                end else begin
                    op2_raw = imm_i;
                    legal   = 1'b1;
                end
            end
            OpcOp: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                op1_raw = rs1_data_i;
                op2_raw = rs2_data_i;
                legal   = (funct7 == 7'h00)
                       || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OpcBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op1_raw = rs1_data_i;
                op2_raw = rs2_data_i;
                aux_raw = imm_b;
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OpcJal: begin
                use_rd  = 1'b1;
                op1_raw = inst_addr_i;
                op2_raw = XLEN'(4);
                aux_raw = imm_j;
                legal   = 1'b1;
            end
            OpcJalr: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                op1_raw = inst_addr_i;
                op2_raw = XLEN'(4);
                aux_raw = rs1_data_i + imm_i;
                legal   = (funct3 == 3'b000);
            end
            OpcLui: begin
                use_rd  = 1'b1;
                op1_raw = imm_u;
                legal   = 1'b1;
            end
            OpcAuipc: begin
                use_rd  = 1'b1;
                op1_raw = inst_addr_i;
                op2_raw = imm_u;
                legal   = 1'b1;
            end
            OpcLoad: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                load_raw = 1'b1;
                op1_raw  = rs1_data_i;
                op2_raw  = imm_i;
                legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OpcStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op1_raw = rs1_data_i;
                op2_raw = imm_s;
                aux_raw = rs2_data_i;
                legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            default: legal = 1'b0;
        endcase
    end

    // Register fields beyond the implemented file (RV32E) make the instruction illegal.
    function automatic logic out_of_range(input logic [4:0] f);
        return (32'(f) >> REG_AW) != 32'd0;
    endfunction

    logic              dec_ill, dec_wen, dec_load;
    logic [REG_AW-1:0] dec_rd;

    assign dec_ill = !legal
                  || (use_rs1 && out_of_range(rs1_f))
                  || (use_rs2 && out_of_range(rs2_f))
                  || (use_rd && out_of_range(rd_f));

    assign rs1_addr_o = (use_rs1 && !dec_ill) ? rs1_f[REG_AW-1:0] : '0;
    assign rs2_addr_o = (use_rs2 && !dec_ill) ? rs2_f[REG_AW-1:0] : '0;
    assign dec_rd     = (use_rd && !dec_ill) ? rd_f[REG_AW-1:0] : '0;
    assign dec_wen    = (dec_rd != '0);
    assign dec_load   = load_raw && !dec_ill;

    logic [NumRegs-1:0] pending_q, pending_d;
    logic               out_valid_q, out_valid_d;
    logic               clr_hit1, clr_hit2, fire;

    // A completing writeback in the same cycle bypasses the pending hit.
    assign clr_hit1   = wb_clr_valid_i && (wb_clr_addr_i == rs1_addr_o);
    assign clr_hit2   = wb_clr_valid_i && (wb_clr_addr_i == rs2_addr_o);
    assign stall_o    = in_valid_i && ((pending_q[rs1_addr_o] && !clr_hit1)
                                    || (pending_q[rs2_addr_o] && !clr_hit2));
    assign in_ready_o = !stall_o && (!out_valid_q || out_ready_i) && !flush_i;
    assign fire       = in_valid_i && in_ready_o;

    always_comb begin
        pending_d = pending_q;
        if (wb_clr_valid_i) begin
            pending_d[wb_clr_addr_i] = 1'b0;
        end
        if (fire && dec_load && dec_rd != '0) begin
            pending_d[dec_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    logic [31:0]       inst_q;
    logic [XLEN-1:0]   pc_q, op1_q, op2_q, aux_q;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q, load_q, ill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pending_q   <= '0;
            inst_q      <= '0;
            pc_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            aux_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            load_q      <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            if (fire) begin
                inst_q <= inst_i;
                pc_q   <= inst_addr_i;
                op1_q  <= dec_ill ? '0 : op1_raw;
                op2_q  <= dec_ill ? '0 : op2_raw;
                aux_q  <= dec_ill ? '0 : aux_raw;
                rd_q   <= dec_rd;
                wen_q  <= dec_wen;
                load_q <= dec_load;
                ill_q  <= dec_ill;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign inst_o      = inst_q;
    assign inst_addr_o = pc_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign aux_o       = aux_q;
    assign rd_addr_o   = rd_q;
    assign reg_wen_o   = wen_q;
    assign is_load_o   = load_q;
    assign illegal_o   = ill_q;

endmodule
